capture_scheduler: RTL and testbench

CAPTURE_SCHEDULER -- requirements
Module: capture_scheduler

---
 rtl/capture_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_capture_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_scheduler.sv
// RTC-triggered capture scheduler: arms on a validated config, opens cfg_win_ms-cycle
// capture windows every cfg_period_s seconds, counting cycles rather than RTC fields.
module capture_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  rtc_ms,
    input  logic [5:0]  rtc_sec,
    input  logic [5:0]  rtc_min,
    input  logic [4:0]  rtc_hour,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_hour,
    input  logic [5:0]  cfg_min,
    input  logic [11:0] cfg_period_s,
    input  logic [9:0]  cfg_win_ms,
    input  logic [7:0]  cfg_count,
    input  logic        abort,
    output logic        cap_en,
    output logic        cap_start,
    output logic        cap_done,
    output logic        busy,
    output logic [7:0]  caps_left,
    output logic        cfg_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [9:0]  win_q, win_d;
    logic [21:0] period_q, period_d;
    logic [21:0] pcnt_q, pcnt_d;
    logic [9:0]  wcnt_q, wcnt_d;
    logic [7:0]  caps_left_q, caps_left_d;
    logic        cap_en_q, cap_en_d;
    logic        cap_start_q, cap_start_d;
    logic        cap_done_q, cap_done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        busy_q, busy_d;

    logic        cfg_bad;
    logic        rtc_hit;
    logic [21:0] period_calc;

    assign cfg_bad = (cfg_hour > 5'd23) || (cfg_min > 6'd59) || (cfg_period_s == '0) ||
                     (cfg_win_ms == '0) || (cfg_win_ms > 10'd999) || (cfg_count == '0);
    assign rtc_hit = (rtc_hour == hour_q) && (rtc_min == min_q) &&
                     (rtc_sec == '0) && (rtc_ms == '0);
    // 4095 * 1000 still fits in 22 bits
    assign period_calc = 22'(cfg_period_s) * 22'd1000;

    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        win_d       = win_q;
        period_d    = period_q;
        pcnt_d      = pcnt_q + 22'd1;
        wcnt_d      = wcnt_q;
        caps_left_d = caps_left_q;
        cap_en_d    = cap_en_q;
        cap_start_d = 1'b0;
        cap_done_d  = 1'b0;
        cfg_err_d   = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            cap_en_d    = 1'b0;
            caps_left_d = '0;
            pcnt_d      = '0;
            wcnt_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pcnt_d = '0;
                    if (cfg_valid) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            hour_d      = cfg_hour;
                            min_d       = cfg_min;
                            win_d       = cfg_win_ms;
                            period_d    = period_calc;
                            caps_left_d = cfg_count;
                            state_d     = ARMED;
                        end
                    end
                end
                ARMED: begin
                    pcnt_d = '0;
                    if (rtc_hit) begin
                        state_d     = CAPTURE;
                        cap_en_d    = 1'b1;
                        cap_start_d = 1'b1;
                        wcnt_d      = 10'd1;
                    end
                end
                CAPTURE: begin
                    // wcnt_q counts cap_en cycles already presented, including this one
                    if (wcnt_q == win_q) begin
                        cap_en_d    = 1'b0;
                        caps_left_d = caps_left_q - 8'd1;
                        if (caps_left_q == 8'd1) begin
                            cap_done_d = 1'b1;
                            state_d    = IDLE;
                            pcnt_d     = '0;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 10'd1;
                    end
                end
                WAIT: begin
                    if (pcnt_q == period_q - 22'd1) begin
                        state_d     = CAPTURE;
                        cap_en_d    = 1'b1;
                        cap_start_d = 1'b1;
                        wcnt_d      = 10'd1;
                        pcnt_d      = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hour_q      <= '0;
            min_q       <= '0;
            win_q       <= '0;
            period_q    <= '0;
            pcnt_q      <= '0;
            wcnt_q      <= '0;
            caps_left_q <= '0;
            cap_en_q    <= 1'b0;
            cap_start_q <= 1'b0;
            cap_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            win_q       <= win_d;
            period_q    <= period_d;
            pcnt_q      <= pcnt_d;
            wcnt_q      <= wcnt_d;
            caps_left_q <= caps_left_d;
            cap_en_q    <= cap_en_d;
            cap_start_q <= cap_start_d;
            cap_done_q  <= cap_done_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cap_en    = cap_en_q;
    assign cap_start = cap_start_q;
    assign cap_done  = cap_done_q;
    assign busy      = busy_q;
    assign caps_left = caps_left_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed bench for capture_scheduler: config-validation table plus cycle-by-cycle
// schedule checks against a closed-form expected timeline.
module tb_capture_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rtc_ms;
    logic [5:0]  rtc_sec;
    logic [5:0]  rtc_min;
    logic [4:0]  rtc_hour;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_hour;
    logic [5:0]  cfg_min;
    logic [11:0] cfg_period_s;
    logic [9:0]  cfg_win_ms;
    logic [7:0]  cfg_count;
    logic        abort;
    logic        cap_en;
    logic        cap_start;
    logic        cap_done;
    logic        busy;
    logic [7:0]  caps_left;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int ms_of_day = 0;

    capture_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .rtc_ms       (rtc_ms),
        .rtc_sec      (rtc_sec),
        .rtc_min      (rtc_min),
        .rtc_hour     (rtc_hour),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_hour     (cfg_hour),
        .cfg_min      (cfg_min),
        .cfg_period_s (cfg_period_s),
        .cfg_win_ms   (cfg_win_ms),
        .cfg_count    (cfg_count),
        .abort        (abort),
        .cap_en       (cap_en),
        .cap_start    (cap_start),
        .cap_done     (cap_done),
        .busy         (busy),
        .caps_left    (caps_left),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  m;
        logic [11:0] p;
        logic [9:0]  w;
        logic [7:0]  n;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [13:0] pk(input logic e_err, input logic e_rdy, input logic e_busy,
                                       input logic e_done, input logic e_start, input logic e_en,
                                       input logic [7:0] e_left);
        return {e_err, e_rdy, e_busy, e_done, e_start, e_en, e_left};
    endfunction

    function automatic logic [13:0] act();
        return pk(cfg_err, cfg_ready, busy, cap_done, cap_start, cap_en, caps_left);
    endfunction

    task automatic set_rtc(input int t);
        ms_of_day = t % 86400000;
        rtc_ms   = 10'(ms_of_day % 1000);
        rtc_sec  = 6'((ms_of_day / 1000) % 60);
        rtc_min  = 6'((ms_of_day / 60000) % 60);
        rtc_hour = 5'(ms_of_day / 3600000);
    endtask

    // RTC value present before an edge is the one sampled by that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        set_rtc(ms_of_day + 1);
    endtask

    task automatic chk(input string name, input logic [13:0] a, input logic [13:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got {err,rdy,busy,done,start,en,left}=0x%0h expected 0x%0h", name, a, e);
        end
    endtask

    task automatic handshake(input logic [4:0] h, input logic [5:0] m, input logic [11:0] p,
                             input logic [9:0] w, input logic [7:0] n);
        cfg_hour = h; cfg_min = m; cfg_period_s = p; cfg_win_ms = w; cfg_count = n;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Tick c (1-based) with first cap_start visible after tick s; d = c - s.
    task automatic run_sched(input string name, input int s, input int p, input int w,
                             input int n, input int total, input int abort_d, input int inj_d);
        for (int c = 1; c <= total; c++) begin
            int d, k, r;
            logic e_en, e_st, e_done, e_busy;
            logic [7:0] e_left;
            tick();
            d = c - s;
            e_en = 1'b0; e_st = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_left = '0;
            if (abort_d >= 0 && d > abort_d) begin
                e_busy = 1'b0;
            end else if (d < 0) begin
                e_busy = 1'b1; e_left = 8'(n);
            end else begin
                k = d / p;
                r = d % p;
                if (k < n - 1) begin
                    e_busy = 1'b1; e_en = (r < w); e_st = (r == 0);
                    e_left = (r < w) ? 8'(n - k) : 8'(n - k - 1);
                end else if (k == n - 1 && r < w) begin
                    e_busy = 1'b1; e_en = 1'b1; e_st = (r == 0); e_left = 8'd1;
                end else if (k == n - 1 && r == w) begin
                    e_done = 1'b1;
                end
            end
            chk($sformatf("%s cycle %0d", name, c), act(), pk(1'b0, !e_busy, e_busy, e_done, e_st, e_en, e_left));
            abort = (abort_d >= 0 && d == abort_d);
            if (inj_d >= 0 && d == inj_d) begin
                cfg_hour = 5'd0; cfg_min = 6'd0; cfg_period_s = 12'd3; cfg_win_ms = 10'd7; cfg_count = 8'd9;
                cfg_valid = 1'b1;
            end else if (inj_d >= 0 && d == inj_d + 1) begin
                cfg_hour = 5'd30; cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
        end
        abort = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{5'd1,  6'd0,  12'd2,    10'd5,    8'd3,   1'b0};
        tbl[1] = '{5'd24, 6'd0,  12'd2,    10'd5,    8'd3,   1'b1};
        tbl[2] = '{5'd23, 6'd59, 12'd60,   10'd999,  8'd255, 1'b0};
        tbl[3] = '{5'd0,  6'd60, 12'd2,    10'd5,    8'd3,   1'b1};
        tbl[4] = '{5'd0,  6'd0,  12'd0,    10'd5,    8'd3,   1'b1};
        tbl[5] = '{5'd0,  6'd0,  12'd2,    10'd0,    8'd3,   1'b1};
        tbl[6] = '{5'd0,  6'd0,  12'd2,    10'd1000, 8'd3,   1'b1};
        tbl[7] = '{5'd0,  6'd0,  12'd2,    10'd5,    8'd0,   1'b1};
        tbl[8] = '{5'd31, 6'd63, 12'd4095, 10'd1,    8'd1,   1'b1};
        tbl[9] = '{5'd0,  6'd0,  12'd4095, 10'd1,    8'd1,   1'b0};

        reset = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        cfg_hour = '0; cfg_min = '0; cfg_period_s = '0; cfg_win_ms = '0; cfg_count = '0;
        set_rtc(45296789);
        #12;
        chk("reset_state", act(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            handshake(tbl[i].h, tbl[i].m, tbl[i].p, tbl[i].w, tbl[i].n);
            chk($sformatf("cfg_resp %0d", i), act(),
                tbl[i].err ? pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)
                           : pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tbl[i].n));
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk($sformatf("cfg_after %0d", i), act(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        end

        // Three 5-cycle windows, 2000 cycles apart, starting at 01:00:00.000
        handshake(5'd1, 6'd0, 12'd2, 10'd5, 8'd3);
        set_rtc(3600000 - 4);
        run_sched("basic", 5, 2000, 5, 3, 5 + 4000 + 15, -1, -1);

        // Abort on third cycle of the second window
        handshake(5'd2, 6'd30, 12'd1, 10'd6, 8'd3);
        set_rtc(9000000 - 2);
        run_sched("abort", 3, 1000, 6, 3, 3 + 3000, 1002, -1);

        // Config offered during WAIT must not disturb the schedule
        handshake(5'd4, 6'd15, 12'd1, 10'd10, 8'd2);
        set_rtc(15300000 - 1);
        run_sched("wait_cfg", 2, 1000, 10, 2, 2 + 1000 + 20, -1, 500);

        // Second window lands across the midnight rollover
        handshake(5'd23, 6'd59, 12'd60, 10'd3, 8'd2);
        set_rtc(86340000 - 2);
        run_sched("day_wrap", 3, 60000, 3, 2, 3 + 60000 + 10, -1, -1);

        // Asynchronous reset in the middle of a window
        handshake(5'd6, 6'd0, 12'd1, 10'd8, 8'd4);
        set_rtc(21600000 - 1);
        run_sched("pre_reset", 2, 1000, 8, 4, 5, -1, -1);
        #2 reset = 1'b0;
        #1 chk("async_reset", act(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        #2 reset = 1'b1;
        tick();
        chk("post_reset_idle", act(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        handshake(5'd7, 6'd7, 12'd5, 10'd20, 8'd11);
        chk("post_reset_cfg", act(), pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd11));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("post_reset_abort", act(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
